txn_capture_fifo: RTL and testbench

- Synthesizable capture stage directly upstream of the testbench monitor layer.
- Snoops a valid/ready bus and stamps each completed handshake with a sequence number and timestamp.
- Buffers the records in a FIFO and presents them over a valid/ready port to the monitor transactor, which converts them into analysis transactions.
- Decouples bus rate from testbench consumption; losses are counted, never silent.

---
 rtl/txn_capture_pkg.sv | 29 ++
 rtl/txn_capture_mem.sv | 27 ++
 rtl/txn_capture_fifo.sv | 167 ++++++++++++++++
 tb/tb_txn_capture_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_capture_pkg.sv
// txn_capture_pkg: shared record layout, FSM encoding and limits for the capture FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package txn_capture_pkg;

   // Default field widths; the top's parameters default to these.
   localparam int CAP_DATA_W = 32;
   localparam int CAP_SEQ_W  = 16;
   localparam int CAP_TS_W   = 32;

   // One captured handshake at the default widths. The top declares a
   // record of the same shape sized by its own parameters.
   typedef struct packed {
      logic [CAP_DATA_W-1:0] data;
      logic [CAP_SEQ_W-1:0]  seq;
      logic [CAP_TS_W-1:0]   ts;
   } txn_rec_t;

   // Encoding matches the state_o port: 0 IDLE, 1 RUN, 2 FLUSH.
   typedef enum logic [1:0] {
      CAP_IDLE  = 2'd0,
      CAP_RUN   = 2'd1,
      CAP_FLUSH = 2'd2
   } cap_state_e;

   // Dropped-record counter saturates here instead of wrapping.
   localparam logic [15:0] OVF_MAX = 16'hFFFF;

endpackage

// File: rtl/txn_capture_mem.sv
// txn_capture_mem: DEPTH x W register array, one write port, one combinational read port.
// Latency: write lands on the clock edge; read data follows rd_addr_i combinationally.
// Backpressure: none; the caller decides when to write.
module txn_capture_mem #(
   parameter int W     = 80,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [W-1:0]             wr_dat_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [W-1:0]             rd_dat_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Storage is not reset: the top masks the read data whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/txn_capture_fifo.sv
// txn_capture_fifo: stamps each snooped valid/ready handshake with seq + timestamp and buffers it (FWFT).
// Latency: a capture at edge N shows on out_* right after edge N when the FIFO was empty.
// Backpressure: out_ready low holds the head stable; captures into a full FIFO are dropped and counted.
// Optional build macro TXN_CAPTURE_PARITY_EN: per-entry even parity plus an out_par_err output.
module txn_capture_fifo
   import txn_capture_pkg::*;
#(
   parameter int DATA_W = CAP_DATA_W,
   parameter int DEPTH  = 16,
   parameter int TS_W   = CAP_TS_W,
   parameter int SEQ_W  = CAP_SEQ_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       flush,
   input  logic                       mon_valid,
   input  logic                       mon_ready,
   input  logic [DATA_W-1:0]          mon_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [SEQ_W-1:0]           out_seq,
   output logic [TS_W-1:0]            out_ts,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                overflow_cnt,
   output logic [1:0]                 state_o
`ifdef TXN_CAPTURE_PARITY_EN
   ,
   output logic                       out_par_err
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int REC_W = DATA_W + SEQ_W + TS_W;
`ifdef TXN_CAPTURE_PARITY_EN
   localparam int MEM_W = REC_W + 1;
`else
   localparam int MEM_W = REC_W;
`endif

   localparam logic [1:0] ST_IDLE  = CAP_IDLE;
   localparam logic [1:0] ST_RUN   = CAP_RUN;
   localparam logic [1:0] ST_FLUSH = CAP_FLUSH;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEQ_W-1:0]  seq;
      logic [TS_W-1:0]   ts;
   } rec_t;

   logic [1:0]       state_q,  state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q,  level_d;
   logic [SEQ_W-1:0] seq_q,    seq_d;
   logic [15:0]      ovf_q,    ovf_d;
   logic [TS_W-1:0]  ts_q;

   logic             capture, pop, push, drop, full;
   rec_t             wr_rec, head_rec;
   logic [MEM_W-1:0] mem_wdat, mem_rdat;

   // flush wins over a same-cycle handshake, so it gates both sides here.
   assign full      = (level_q == LVL_W'(DEPTH));
   assign out_valid = (level_q != '0);
   assign capture   = mon_valid && mon_ready && enable && (state_q == ST_RUN) && !flush;
   assign pop       = out_valid && out_ready && !flush;
   // A full FIFO still accepts a capture when the head leaves in the same cycle.
   assign push      = capture && (!full || pop);
   assign drop      = capture && full && !pop;

   assign wr_rec = '{data: mon_data, seq: seq_q, ts: ts_q};

`ifdef TXN_CAPTURE_PARITY_EN
   logic head_par;
   assign mem_wdat    = {^mon_data, wr_rec};
   assign head_rec    = rec_t'(mem_rdat[REC_W-1:0]);
   assign head_par    = mem_rdat[REC_W];
   assign out_par_err = out_valid && ((^head_rec.data) != head_par);
`else
   assign mem_wdat = wr_rec;
   assign head_rec = mem_rdat;
`endif

   txn_capture_mem #(
      .W     (MEM_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_dat_i  (mem_wdat),
      .rd_addr_i (rd_ptr_q),
      .rd_dat_o  (mem_rdat)
   );

   // Record fields read as zero while empty so stale storage never leaks out.
   assign out_data     = out_valid ? head_rec.data : '0;
   assign out_seq      = out_valid ? head_rec.seq  : '0;
   assign out_ts       = out_valid ? head_rec.ts   : '0;
   assign level        = level_q;
   assign overflow_cnt = ovf_q;
   assign state_o      = state_q;

   // FSM: flush from any state; FLUSH lasts one cycle and then follows enable.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:  if (enable)  state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_IDLE;
            ST_FLUSH: state_d = enable ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Pointer, occupancy, sequence and loss bookkeeping; flush clears all but the timestamp.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         seq_d    = '0;
         ovf_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      level_d = level_q + LVL_W'(1);
         else if (pop && !push) level_d = level_q - LVL_W'(1);
         // Dropped captures still consume a sequence number so the gap is visible.
         if (capture) seq_d = seq_q + SEQ_W'(1);
         if (drop && (ovf_q != OVF_MAX)) ovf_d = ovf_q + 16'd1;
      end
   end

   // State registers with synchronous reset; the timestamp free-runs from reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         seq_q    <= '0;
         ovf_q    <= '0;
         ts_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         ts_q     <= ts_q + TS_W'(1);
      end
   end

endmodule

// File: tb/tb_txn_capture_fifo.sv
// tb_txn_capture_fifo: table vectors, directed corner sequences and random traffic vs a queue model.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: out_ready is driven per test, including long stalls to force overflow.
module tb_txn_capture_fifo;
   import txn_capture_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int TS_W   = 32;
   localparam int SEQ_W  = 16;
   localparam int LVL_W  = $clog2(DEPTH) + 1;
   localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2;

   logic              clk = 1'b0;
   logic              rst, enable, flush, mon_valid, mon_ready, out_ready;
   logic [DATA_W-1:0] mon_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [SEQ_W-1:0]  out_seq;
   logic [TS_W-1:0]   out_ts;
   logic [LVL_W-1:0]  level;
   logic [15:0]       overflow_cnt;
   logic [1:0]        state_o;
`ifdef TXN_CAPTURE_PARITY_EN
   logic              out_par_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   txn_capture_fifo #(
      .DATA_W (DATA_W), .DEPTH (DEPTH), .TS_W (TS_W), .SEQ_W (SEQ_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .flush        (flush),
      .mon_valid    (mon_valid),
      .mon_ready    (mon_ready),
      .mon_data     (mon_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_seq      (out_seq),
      .out_ts       (out_ts),
      .level        (level),
      .overflow_cnt (overflow_cnt),
      .state_o      (state_o)
`ifdef TXN_CAPTURE_PARITY_EN
      ,
      .out_par_err  (out_par_err)
`endif
   );

   // Reference model: list of records plus counters, following the behavioural rules.
   txn_rec_t    mq[$];
   logic [15:0] m_seq;
   logic [31:0] m_ts;
   logic [15:0] m_ovf;
   int          m_st;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      txn_rec_t r;
      bit cap, pp;
      if (rst) begin
         mq.delete();
         m_seq = 0; m_ts = 0; m_ovf = 0; m_st = S_IDLE;
         return;
      end
      if (flush) begin
         mq.delete();
         m_seq = 0; m_ovf = 0; m_st = S_FLUSH;
      end else begin
         cap = mon_valid && mon_ready && enable && (m_st == S_RUN);
         pp  = (mq.size() > 0) && out_ready;
         if (pp) void'(mq.pop_front());
         if (cap) begin
            if (mq.size() < DEPTH) begin
               r.data = mon_data; r.seq = m_seq; r.ts = m_ts;
               mq.push_back(r);
            end else if (m_ovf != 16'hFFFF) begin
               m_ovf = m_ovf + 16'd1;
            end
            m_seq = m_seq + 16'd1;
         end
         if (m_st == S_IDLE)     m_st = enable ? S_RUN : S_IDLE;
         else if (m_st == S_RUN) m_st = enable ? S_RUN : S_IDLE;
         else                    m_st = enable ? S_RUN : S_IDLE;
      end
      m_ts = m_ts + 32'd1;
   endtask

   task automatic compare_model();
      chk("m_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("m_level", 64'(level), 64'(mq.size()));
      chk("m_ovf", 64'(overflow_cnt), 64'(m_ovf));
      chk("m_state", 64'(state_o), 64'(m_st));
      if (mq.size() != 0) begin
         chk("m_data", 64'(out_data), 64'(mq[0].data));
         chk("m_seq", 64'(out_seq), 64'(mq[0].seq));
         chk("m_ts", 64'(out_ts), 64'(mq[0].ts));
      end else begin
         chk("m_data_empty", 64'(out_data), 64'd0);
         chk("m_seq_empty", 64'(out_seq), 64'd0);
         chk("m_ts_empty", 64'(out_ts), 64'd0);
      end
`ifdef TXN_CAPTURE_PARITY_EN
      chk("m_par_err", 64'(out_par_err), 64'd0);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic hs(input logic on, input logic [31:0] d);
      mon_valid = on; mon_ready = on; mon_data = d;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
      hs(1'b0, 32'h0);
      step(); step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        en, fl, h, ordy;
      logic [31:0] dat;
      logic        e_vld;
      int          e_lvl, e_st;
      logic [31:0] e_dat;
      int          e_seq;
   } vec_t;
   vec_t tbl [11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            en fl hs rdy data    | vld lvl st data    seq
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 0, 1, 32'h00, 0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1, 1, 32'h11, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 1'b1, 2, 1, 32'h11, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h99, 1'b1, 2, 0, 32'h11, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1, 0, 32'h22, 1};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h98, 1'b1, 1, 1, 32'h22, 1};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 1, 1, 32'h33, 2};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h97, 1'b0, 0, 2, 32'h00, 0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h96, 1'b0, 0, 1, 32'h00, 0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 1, 1, 32'h44, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 0, 0, 32'h00, 0};

      // Reset state
      do_reset();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_ovf", 64'(overflow_cnt), 64'd0);
      chk("rst_state", 64'(state_o), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);

      // Table vectors
      for (int i = 0; i < 11; i++) begin
         enable = tbl[i].en; flush = tbl[i].fl; out_ready = tbl[i].ordy;
         hs(tbl[i].h, tbl[i].dat);
         step();
         chk($sformatf("tbl%0d_vld", i), 64'(out_valid), 64'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_lvl", i), 64'(level), 64'(tbl[i].e_lvl));
         chk($sformatf("tbl%0d_st", i), 64'(state_o), 64'(tbl[i].e_st));
         chk($sformatf("tbl%0d_dat", i), 64'(out_data), 64'(tbl[i].e_dat));
         chk($sformatf("tbl%0d_seq", i), 64'(out_seq), 64'(tbl[i].e_seq));
      end
      flush = 1'b0; out_ready = 1'b0; hs(1'b0, 32'h0);

      // First capture latency and timestamp
      do_reset();
      enable = 1'b1;
      repeat (10) step();
      hs(1'b1, 32'hA5A5_0001);
      step();
      hs(1'b0, 32'h0);
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_data", 64'(out_data), 64'hA5A5_0001);
      chk("first_seq", 64'(out_seq), 64'd0);
      chk("first_ts", 64'(out_ts), 64'd10);

      // Overflow, then full with simultaneous pop, then drain
      do_reset();
      enable = 1'b1;
      step();
      for (int i = 0; i < 18; i++) begin
         hs(1'b1, 32'h1000 + 32'(i));
         step();
      end
      hs(1'b0, 32'h0);
      chk("ovf_level", 64'(level), 64'd16);
      chk("ovf_cnt", 64'(overflow_cnt), 64'd2);
      chk("ovf_head_seq", 64'(out_seq), 64'd0);
      chk("ovf_head_dat", 64'(out_data), 64'h1000);
      out_ready = 1'b1;
      hs(1'b1, 32'h2000);
      step();
      hs(1'b0, 32'h0);
      out_ready = 1'b0;
      chk("fullpop_level", 64'(level), 64'd16);
      chk("fullpop_ovf", 64'(overflow_cnt), 64'd2);
      chk("fullpop_head_seq", 64'(out_seq), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain_seq%0d", i), 64'(out_seq), (i < 15) ? 64'(i + 1) : 64'd18);
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty", 64'(out_valid), 64'd0);

      // Flush together with a handshake
      do_reset();
      enable = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         hs(1'b1, 32'h3000 + 32'(i));
         step();
      end
      chk("pre_flush_level", 64'(level), 64'd5);
      flush = 1'b1;
      hs(1'b1, 32'hDEAD);
      step();
      flush = 1'b0;
      hs(1'b0, 32'h0);
      chk("flush_level", 64'(level), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_state", 64'(state_o), 64'd2);
      hs(1'b1, 32'h3100);
      for (int k = 0; k < 4 && !out_valid; k++) step();
      hs(1'b0, 32'h0);
      chk("flush_recover_vld", 64'(out_valid), 64'd1);
      chk("flush_recover_seq", 64'(out_seq), 64'd0);
      chk("flush_recover_dat", 64'(out_data), 64'h3100);

      // Disabled capture; buffered data drains in IDLE
      do_reset();
      enable = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         hs(1'b1, 32'h4000 + 32'(i));
         step();
      end
      enable = 1'b0;
      hs(1'b1, 32'h4444);
      repeat (8) step();
      hs(1'b0, 32'h0);
      chk("dis_level", 64'(level), 64'd3);
      chk("dis_state", 64'(state_o), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("dis_drain_seq%0d", i), 64'(out_seq), 64'(i));
         step();
      end
      out_ready = 1'b0;
      chk("dis_drained", 64'(level), 64'd0);
      enable = 1'b1;
      step();
      hs(1'b1, 32'h4100);
      step();
      hs(1'b0, 32'h0);
      chk("dis_seq_kept", 64'(out_seq), 64'd3);

      // Reset mid-drain
      do_reset();
      enable = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         hs(1'b1, 32'h5000 + 32'(i));
         step();
      end
      hs(1'b0, 32'h0);
      out_ready = 1'b1;
      step();
      chk("middrain_level", 64'(level), 64'd7);
      rst = 1'b1;
      hs(1'b1, 32'h5555);
      step();
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_level", 64'(level), 64'd0);
      chk("midrst_state", 64'(state_o), 64'd0);
      chk("midrst_data", 64'(out_data), 64'd0);
      chk("midrst_ovf", 64'(overflow_cnt), 64'd0);
      rst = 1'b0;
      out_ready = 1'b0;
      hs(1'b0, 32'h0);
      step();
      hs(1'b1, 32'h5100);
      step();
      hs(1'b0, 32'h0);
      chk("midrst_ts_restart", 64'(out_ts), 64'd1);
      chk("midrst_seq_restart", 64'(out_seq), 64'd0);

      // Random traffic against the model, with windows of varying drain pressure
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int rdy_pct;
         rdy_pct   = ((c / 200) % 3 == 0) ? 10 : (((c / 200) % 3 == 1) ? 50 : 90);
         rst       = ($urandom_range(0, 999) == 0);
         enable    = ($urandom_range(0, 15) != 0);
         flush     = ($urandom_range(0, 99) == 0);
         mon_valid = ($urandom_range(0, 3) != 0);
         mon_ready = ($urandom_range(0, 3) != 0);
         mon_data  = $urandom;
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         step();
      end
      rst = 1'b0; flush = 1'b0; hs(1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
